// File: rtl/dram_burst_if.sv
// Command/data bundle between a bench master and the dram_burst memory model.
interface dram_burst_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]  addr;
    logic               rd;
    logic               wr;
    logic [BURST_W-1:0] len;
    logic [DATA_W-1:0]  wr_dat;
    logic               wr_vld;
    logic [DATA_W-1:0]  rd_dat;
    logic               rd_vld;
    logic               busy;
    logic               err;

    modport master (
        output addr, rd, wr, len, wr_dat, wr_vld,
        input  rd_dat, rd_vld, busy, err
    );

    modport slave (
        input  addr, rd, wr, len, wr_dat, wr_vld,
        output rd_dat, rd_vld, busy, err
    );
endinterface

// File: rtl/dram_burst.sv
// Word memory with Len+1 beat bursts: first read beat RD_LAT cycles after the command edge.
// Write beats after the first stall on wr_vld low; commands arriving while busy are dropped.
module dram_burst #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int RD_LAT  = 2,
    parameter int BURST_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dram_burst_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RWAIT  = 2'd1;
    localparam logic [1:0] S_RBURST = 2'd2;
    localparam logic [1:0] S_WBURST = 2'd3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [BURST_W:0]  r_beats;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_rd_dat;
    logic              r_rd_vld;
    logic              r_err;

    logic              w_idle;
    logic              w_addr_bad;
    logic              w_cmd_err;
    logic              w_rd_go;
    logic              w_wr_go;
    logic              w_we;
    logic [IDX_W-1:0]  w_cmd_idx;
    logic [IDX_W-1:0]  w_waddr;

    // Burst pointer wraps from the last word back to word 0.
    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_addr_bad = ({1'b0, bus.addr} >= DEPTH_X);
    assign w_cmd_err  = w_idle && (bus.rd || bus.wr) && ((bus.rd && bus.wr) || w_addr_bad);
    assign w_rd_go    = w_idle && bus.rd && !bus.wr && !w_addr_bad;
    assign w_wr_go    = w_idle && bus.wr && !bus.rd && !w_addr_bad;
    assign w_cmd_idx  = IDX_W'(bus.addr);

    assign w_we    = w_wr_go || ((r_state == S_WBURST) && bus.wr_vld);
    assign w_waddr = w_wr_go ? w_cmd_idx : r_ptr;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_waddr] <= bus.wr_dat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_beats  <= '0;
            r_lat    <= '0;
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= w_cmd_err;
            r_rd_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_go) begin
                        r_ptr   <= w_cmd_idx;
                        r_beats <= {1'b0, bus.len} + 1'b1;
                        if (RD_LAT == 1) begin
                            r_state <= S_RBURST;
                        end else begin
                            r_state <= S_RWAIT;
                            r_lat   <= LAT_W'(RD_LAT - 1);
                        end
                    end else if (w_wr_go && (bus.len != '0)) begin
                        r_ptr   <= f_inc(w_cmd_idx);
                        r_beats <= {1'b0, bus.len};
                        r_state <= S_WBURST;
                    end
                end
                S_RWAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == LAT_W'(1)) r_state <= S_RBURST;
                end
                S_RBURST: begin
                    r_rd_dat <= r_mem[r_ptr];
                    r_rd_vld <= 1'b1;
                    r_ptr    <= f_inc(r_ptr);
                    r_beats  <= r_beats - 1'b1;
                    if (r_beats == (BURST_W + 1)'(1)) r_state <= S_IDLE;
                end
                default: begin
                    if (bus.wr_vld) begin
                        r_ptr   <= f_inc(r_ptr);
                        r_beats <= r_beats - 1'b1;
                        if (r_beats == (BURST_W + 1)'(1)) r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.rd_dat = r_rd_dat;
    assign bus.rd_vld = r_rd_vld;
    assign bus.busy   = !w_idle;
    assign bus.err    = r_err;
endmodule
